// File: rtl/pll_lock_sequencer.sv
// Reset/power sequencer for a single PLL: pulses PLL reset, qualifies LOCKED, releases fabric reset,
// retries on lock timeout and parks in a sticky fault after repeated failures.
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwrdwn_req_i,
   input  logic             restart_i,
   input  logic             pll_locked_i,
   output logic             pll_rst_o,
   output logic             pll_pwrdwn_o,
   output logic             sys_rst_n_o,
   output logic             ready_o,
   output logic             fault_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] lock_loss_cnt_o
);

   localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
   localparam int unsigned StbW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned ToW  = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned RetW = $clog2(MAX_RETRIES + 1);

   localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);
   localparam logic [StbW-1:0] StbLast = StbW'(STABLE_CYCLES - 1);
   localparam logic [ToW-1:0]  ToLast  = ToW'(LOCK_TIMEOUT - 1);
   localparam logic [RetW-1:0] RetMax  = RetW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StRstHold  = 3'd0,
      StWaitLock = 3'd1,
      StStable   = 3'd2,
      StRun      = 3'd3,
      StFault    = 3'd4,
      StPwrdn    = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
   logic [StbW-1:0]   stb_cnt_q, stb_cnt_d;
   logic [ToW-1:0]    to_cnt_q, to_cnt_d;
   logic [RetW-1:0]   retry_q, retry_d, retry_inc;
   logic [CNT_W-1:0]  loss_q, loss_d;
   logic [1:0]        sync_q;
   logic              locked_s, to_hit;
   logic              pll_rst_q, pll_pwrdwn_q, sys_rst_n_q, ready_q, fault_q;

   assign locked_s  = sync_q[1];
   assign to_hit    = (to_cnt_q == ToLast);
   assign retry_inc = retry_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      stb_cnt_d = stb_cnt_q;
      to_cnt_d  = to_cnt_q;
      retry_d   = retry_q;
      loss_d    = loss_q;
      if (pwrdwn_req_i) begin
         state_d = StPwrdn;
      end else begin
         unique case (state_q)
            StRstHold: begin
               if (rst_cnt_q == RstLast) state_d = StWaitLock;
               else                      rst_cnt_d = rst_cnt_q + 1'b1;
            end
            StWaitLock, StStable: begin
               // Timeout wins over a STABLE->RUN completion on the same edge.
               if (to_hit) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc == RetMax) ? StFault : StRstHold;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
                  if (state_q == StWaitLock) begin
                     if (locked_s) state_d = StStable;
                  end else if (!locked_s) begin
                     state_d = StWaitLock;
                  end else if (stb_cnt_q == StbLast) begin
                     state_d = StRun;
                     retry_d = '0;
                  end else begin
                     stb_cnt_d = stb_cnt_q + 1'b1;
                  end
               end
            end
            StRun: begin
               if (!locked_s) begin
                  state_d = StRstHold;
                  if (loss_q != '1) loss_d = loss_q + 1'b1;
               end
            end
            StFault: begin
               if (restart_i) begin
                  state_d = StRstHold;
                  retry_d = '0;
               end
            end
            StPwrdn: begin
               state_d = StRstHold;
               retry_d = '0;
            end
            default: state_d = StRstHold;
         endcase
      end
      // Phase counters restart on every state change; the timeout only restarts on a new attempt.
      if (state_d != state_q) begin
         rst_cnt_d = '0;
         stb_cnt_d = '0;
      end
      if (state_q == StRstHold && state_d == StWaitLock) to_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StRstHold;
         rst_cnt_q    <= '0;
         stb_cnt_q    <= '0;
         to_cnt_q     <= '0;
         retry_q      <= '0;
         loss_q       <= '0;
         sync_q       <= 2'b00;
         pll_rst_q    <= 1'b1;
         pll_pwrdwn_q <= 1'b0;
         sys_rst_n_q  <= 1'b0;
         ready_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         stb_cnt_q    <= stb_cnt_d;
         to_cnt_q     <= to_cnt_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         sync_q       <= {sync_q[0], pll_locked_i};
         pll_rst_q    <= (state_d == StRstHold) || (state_d == StFault) || (state_d == StPwrdn);
         pll_pwrdwn_q <= (state_d == StPwrdn);
         sys_rst_n_q  <= (state_d == StRun);
         ready_q      <= (state_d == StRun);
         fault_q      <= (state_d == StFault);
      end
   end

   assign pll_rst_o       = pll_rst_q;
   assign pll_pwrdwn_o    = pll_pwrdwn_q;
   assign sys_rst_n_o     = sys_rst_n_q;
   assign ready_o         = ready_q;
   assign fault_o         = fault_q;
   assign state_o         = state_q;
   assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: timestamp-based reference model checked every cycle, directed
// bring-up/glitch/timeout/lock-loss/power-down/reset scenarios, then randomized stimulus.
module tb_pll_lock_sequencer;

   localparam int RC = 4, LT = 20, SC = 8, MR = 2, CW = 2;
   localparam int LossMax = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pwrdwn_req_i = 1'b0;
   logic          restart_i = 1'b0;
   logic          pll_locked_i = 1'b0;
   logic          pll_rst_o, pll_pwrdwn_o, sys_rst_n_o, ready_o, fault_o;
   logic [2:0]    state_o;
   logic [CW-1:0] lock_loss_cnt_o;

   int checks = 0;
   int failures = 0;

   pll_lock_sequencer #(
      .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pwrdwn_req_i(pwrdwn_req_i), .restart_i(restart_i),
      .pll_locked_i(pll_locked_i), .pll_rst_o(pll_rst_o), .pll_pwrdwn_o(pll_pwrdwn_o),
      .sys_rst_n_o(sys_rst_n_o), .ready_o(ready_o), .fault_o(fault_o), .state_o(state_o),
      .lock_loss_cnt_o(lock_loss_cnt_o)
   );

   always #5 clk = ~clk;

   // Model: state plus the edge index at which it was entered; the lock input reaches the
   // decision logic two edges after it is sampled.
   int m_st, m_n, m_enter, m_attempt, m_retries, m_losses;
   bit m_d1, m_d2;

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_st = 0; m_n = 0; m_enter = 0; m_attempt = 0; m_retries = 0; m_losses = 0;
      m_d1 = 1'b0; m_d2 = 1'b0;
   endfunction

   function automatic void model_step();
      bit ls;
      int nxt;
      m_n++;
      ls = m_d2; m_d2 = m_d1; m_d1 = pll_locked_i;
      nxt = m_st;
      if (pwrdwn_req_i) nxt = 5;
      else begin
         case (m_st)
            0: if (m_n - m_enter == RC) begin nxt = 1; m_attempt = m_n; end
            1, 2: begin
               if (m_n - m_attempt == LT) begin
                  m_retries++;
                  nxt = (m_retries == MR) ? 4 : 0;
               end else if (m_st == 1) begin
                  if (ls) nxt = 2;
               end else if (!ls) nxt = 1;
               else if (m_n - m_enter == SC) begin nxt = 3; m_retries = 0; end
            end
            3: if (!ls) begin nxt = 0; if (m_losses < LossMax) m_losses++; end
            4: if (restart_i) begin nxt = 0; m_retries = 0; end
            5: begin nxt = 0; m_retries = 0; end
            default: nxt = 0;
         endcase
      end
      if (nxt != m_st) m_enter = m_n;
      m_st = nxt;
   endfunction

   function automatic void compare();
      string tag;
      tag = $sformatf("@%0d", m_n);
      chk({"state", tag}, int'(state_o), m_st);
      chk({"pll_rst", tag}, int'(pll_rst_o), int'(m_st == 0 || m_st == 4 || m_st == 5));
      chk({"pll_pwrdwn", tag}, int'(pll_pwrdwn_o), int'(m_st == 5));
      chk({"sys_rst_n", tag}, int'(sys_rst_n_o), int'(m_st == 3));
      chk({"ready", tag}, int'(ready_o), int'(m_st == 3));
      chk({"fault", tag}, int'(fault_o), int'(m_st == 4));
      chk({"lock_loss", tag}, int'(lock_loss_cnt_o), m_losses);
      chk({"inv_rst_overlap", tag}, int'(sys_rst_n_o & pll_rst_o), 0);
      chk({"inv_sys_not_run", tag}, int'(sys_rst_n_o && state_o != 3'd3), 0);
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         model_step();
         #1;
         compare();
      end
   end

   // Leaves the bench just after reset release, i.e. at the start of cycle 0.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      compare();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input int st, input int lim, input string nm);
      bit hit = 1'b0;
      for (int i = 0; i < lim && !hit; i++) begin
         @(negedge clk);
         if (state_o == 3'(st)) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL %s: state_o=%0d, required %0d within %0d cycles", nm, state_o, st, lim);
      end
   endtask

   task automatic scen_bringup();
      pll_locked_i = 1'b0; pwrdwn_req_i = 1'b0; restart_i = 1'b0;
      do_reset();
      chk("s1_c0_state", int'(state_o), 0);
      chk("s1_c0_pll_rst", int'(pll_rst_o), 1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 5) pll_locked_i = 1'b1;
         if (k == 3) chk("s1_c3_pll_rst", int'(pll_rst_o), 1);
         if (k == 4) chk("s1_c4_pll_rst", int'(pll_rst_o), 0);
         if (k == 7) chk("s1_c7_state", int'(state_o), 1);
         if (k == 8) chk("s1_c8_state", int'(state_o), 2);
         if (k == 15) chk("s1_c15_sys_rst_n", int'(sys_rst_n_o), 0);
         if (k == 16) chk("s1_c16_state", int'(state_o), 3);
         if (k == 16) chk("s1_c16_sys_rst_n", int'(sys_rst_n_o), 1);
      end
   endtask

   int exp_loss[4] = '{1, 2, 3, 3};

   initial begin
      model_reset();
      scen_bringup();

      // Glitch during STABLE: one low sample at edge 7 bounces back to WAIT_LOCK at cycle 9.
      pll_locked_i = 1'b1;
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 6) pll_locked_i = 1'b0;
         if (k == 7) pll_locked_i = 1'b1;
         if (k == 5) chk("s2_c5_state", int'(state_o), 2);
         if (k == 9) chk("s2_c9_state", int'(state_o), 1);
         if (k == 10) chk("s2_c10_state", int'(state_o), 2);
         if (k == 17) chk("s2_c17_state", int'(state_o), 2);
         if (k == 18) chk("s2_c18_state", int'(state_o), 3);
      end

      // Never lock: two 20-cycle timeouts, then FAULT; restart leaves FAULT.
      pll_locked_i = 1'b0;
      do_reset();
      for (int k = 1; k <= 51; k++) begin
         @(negedge clk);
         if (k == 23) chk("s3_c23_state", int'(state_o), 1);
         if (k == 24) chk("s3_c24_state", int'(state_o), 0);
         if (k == 28) chk("s3_c28_state", int'(state_o), 1);
         if (k == 47) chk("s3_c47_fault", int'(fault_o), 0);
         if (k == 48) chk("s3_c48_state", int'(state_o), 4);
         if (k == 48) chk("s3_c48_fault", int'(fault_o), 1);
         if (k == 50) chk("s3_c50_state", int'(state_o), 4);
         if (k == 50) restart_i = 1'b1;
         if (k == 51) begin
            restart_i = 1'b0;
            chk("s3_c51_state", int'(state_o), 0);
            chk("s3_c51_fault", int'(fault_o), 0);
         end
      end

      // Lose lock in RUN four times; counter saturates at 3.
      pll_locked_i = 1'b1;
      wait_state(3, 60, "s4_reach_run");
      for (int i = 0; i < 4; i++) begin
         pll_locked_i = 1'b0;
         repeat (3) @(negedge clk);
         chk($sformatf("s4_loss%0d_sys_rst_n", i), int'(sys_rst_n_o), 0);
         chk($sformatf("s4_loss%0d_cnt", i), int'(lock_loss_cnt_o), exp_loss[i]);
         pll_locked_i = 1'b1;
         wait_state(3, 60, "s4_rerun");
      end

      // Power-down from RUN and from FAULT.
      pwrdwn_req_i = 1'b1;
      @(negedge clk);
      chk("s5_run_pd_state", int'(state_o), 5);
      chk("s5_run_pd_pwrdwn", int'(pll_pwrdwn_o), 1);
      chk("s5_run_pd_loss", int'(lock_loss_cnt_o), 3);
      pwrdwn_req_i = 1'b0;
      @(negedge clk);
      chk("s5_run_pd_exit", int'(state_o), 0);
      pll_locked_i = 1'b0;
      wait_state(4, 120, "s5_reach_fault");
      pwrdwn_req_i = 1'b1;
      @(negedge clk);
      chk("s5_flt_pd_state", int'(state_o), 5);
      chk("s5_flt_pd_pll_rst", int'(pll_rst_o), 1);
      pwrdwn_req_i = 1'b0;
      @(negedge clk);
      chk("s5_flt_pd_exit", int'(state_o), 0);
      repeat (24) @(negedge clk);
      chk("s5_retry_cleared", int'(state_o), 0);
      repeat (24) @(negedge clk);
      chk("s5_second_fault", int'(state_o), 4);

      // Async reset during STABLE, then repeat the bring-up.
      pll_locked_i = 1'b1;
      do_reset();
      wait_state(2, 20, "s6_reach_stable");
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("s6_state", int'(state_o), 0);
      chk("s6_pll_rst", int'(pll_rst_o), 1);
      chk("s6_pwrdwn", int'(pll_pwrdwn_o), 0);
      chk("s6_sys_rst_n", int'(sys_rst_n_o), 0);
      chk("s6_ready", int'(ready_o), 0);
      chk("s6_fault", int'(fault_o), 0);
      chk("s6_loss", int'(lock_loss_cnt_o), 0);
      scen_bringup();

      // Randomized phase, checked cycle by cycle by the model.
      begin
         int seg = 0;
         for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (seg == 0) begin
               pll_locked_i = ($urandom_range(0, 3) != 0);
               seg = pll_locked_i ? $urandom_range(1, 40) : $urandom_range(1, 25);
            end
            seg--;
            if (pwrdwn_req_i) pwrdwn_req_i = ($urandom_range(0, 3) != 0);
            else              pwrdwn_req_i = ($urandom_range(0, 149) == 0);
            restart_i = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 799) == 0) do_reset();
         end
      end
      pwrdwn_req_i = 1'b0;
      restart_i = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation did not complete, required completion before 2ms");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
